// File: rtl/rd_pipeline_tracker.sv
// Tracks rd through EX/MEM/WB for forwarding; stalls the front end on load-use and multi-cycle divide.
// Registered stage qualifiers, combinational stall_o; divide holds EX for DIV_LATENCY cycles.
module rd_pipeline_tracker #(
    parameter int DIV_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid_i,
    input  logic       rd_we_id_i,
    input  logic [4:0] rd_address_id_i,
    input  logic [4:0] rs1_address_id_i,
    input  logic [4:0] rs2_address_id_i,
    input  logic       rs1_used_id_i,
    input  logic       rs2_used_id_i,
    input  logic       mem_read_id_i,
    input  logic       div_id_i,
    input  logic       flush_i,
    output logic       rd_we_ex_o,
    output logic [4:0] rd_address_ex_o,
    output logic       rd_we_mem_o,
    output logic [4:0] rd_address_mem_o,
    output logic       rd_we_wb_o,
    output logic [4:0] rd_address_wb_o,
    output logic       stall_o,
    output logic       div_busy_o
);

    localparam logic [4:0] LP_DIV_LOAD = 5'(DIV_LATENCY - 1);
    localparam logic       LP_MULTI    = (DIV_LATENCY > 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_cnt;

    logic       r_ex_valid, r_ex_we, r_ex_load;
    logic [4:0] r_ex_rd;
    logic       r_mem_valid, r_mem_we;
    logic [4:0] r_mem_rd;
    logic       r_wb_valid, r_wb_we;
    logic [4:0] r_wb_rd;

    logic       w_div_busy;
    logic       w_load_use;
    logic       w_take_id;

    assign w_load_use = r_ex_valid && r_ex_load && (r_ex_rd != 5'd0) && id_valid_i &&
                        ((rs1_used_id_i && (rs1_address_id_i == r_ex_rd)) ||
                         (rs2_used_id_i && (rs2_address_id_i == r_ex_rd)));

    // Busy wins over everything, so a flush during a divide is deliberately ignored here.
    assign w_take_id = !w_div_busy && !w_load_use && !flush_i && id_valid_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take_id && div_id_i && LP_MULTI) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 5'd1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_div_busy = (r_state == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst)                                           r_cnt <= 5'd0;
        else if (r_state == S_IDLE && w_state_nxt == S_BUSY) r_cnt <= LP_DIV_LOAD;
        else if (w_div_busy)                               r_cnt <= r_cnt - 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_we     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_ex_rd     <= 5'd0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_rd    <= 5'd0;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_rd     <= 5'd0;
        end else begin
            r_wb_valid <= r_mem_valid;
            r_wb_we    <= r_mem_we;
            r_wb_rd    <= r_mem_rd;
            if (w_div_busy) begin
                r_mem_valid <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_rd    <= 5'd0;
            end else begin
                r_mem_valid <= r_ex_valid;
                r_mem_we    <= r_ex_we;
                r_mem_rd    <= r_ex_rd;
                if (w_take_id) begin
                    r_ex_valid <= 1'b1;
                    r_ex_we    <= rd_we_id_i;
                    r_ex_load  <= mem_read_id_i;
                    r_ex_rd    <= rd_address_id_i;
                end else begin
                    r_ex_valid <= 1'b0;
                    r_ex_we    <= 1'b0;
                    r_ex_load  <= 1'b0;
                    r_ex_rd    <= 5'd0;
                end
            end
        end
    end

    assign rd_we_ex_o       = r_ex_valid && r_ex_we && (r_ex_rd != 5'd0);
    assign rd_address_ex_o  = r_ex_valid ? r_ex_rd : 5'd0;
    assign rd_we_mem_o      = r_mem_valid && r_mem_we && (r_mem_rd != 5'd0);
    assign rd_address_mem_o = r_mem_valid ? r_mem_rd : 5'd0;
    assign rd_we_wb_o       = r_wb_valid && r_wb_we && (r_wb_rd != 5'd0);
    assign rd_address_wb_o  = r_wb_valid ? r_wb_rd : 5'd0;
    assign div_busy_o       = w_div_busy;
    assign stall_o          = w_load_use || w_div_busy;

endmodule

// File: tb/tb_rd_pipeline_tracker.sv
// Directed and random stimulus for rd_pipeline_tracker, checked against an instruction-level model.
module tb_rd_pipeline_tracker;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_i, rd_we_id_i, rs1_used_id_i, rs2_used_id_i;
    logic       mem_read_id_i, div_id_i, flush_i;
    logic [4:0] rd_address_id_i, rs1_address_id_i, rs2_address_id_i;
    logic       rd_we_ex_o, rd_we_mem_o, rd_we_wb_o, stall_o, div_busy_o;
    logic [4:0] rd_address_ex_o, rd_address_mem_o, rd_address_wb_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rd_pipeline_tracker #(.DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .rd_we_id_i(rd_we_id_i),
        .rd_address_id_i(rd_address_id_i),
        .rs1_address_id_i(rs1_address_id_i), .rs2_address_id_i(rs2_address_id_i),
        .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
        .mem_read_id_i(mem_read_id_i), .div_id_i(div_id_i), .flush_i(flush_i),
        .rd_we_ex_o(rd_we_ex_o), .rd_address_ex_o(rd_address_ex_o),
        .rd_we_mem_o(rd_we_mem_o), .rd_address_mem_o(rd_address_mem_o),
        .rd_we_wb_o(rd_we_wb_o), .rd_address_wb_o(rd_address_wb_o),
        .stall_o(stall_o), .div_busy_o(div_busy_o)
    );

    // Model: each stage holds an instruction record; a divide owns EX for div_left more cycles.
    typedef struct {
        bit       v;
        bit       we;
        bit [4:0] rd;
        bit       ld;
    } instr_t;

    instr_t m_ex, m_mem, m_wb;
    int     div_left;
    bit     model_ok = 1'b0;

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.we = 0; b.rd = 0; b.ld = 0;
        return b;
    endfunction

    function automatic bit fwd_we(input instr_t s);
        return s.v && s.we && (s.rd != 0);
    endfunction

    function automatic bit [4:0] fwd_rd(input instr_t s);
        return s.v ? s.rd : 5'd0;
    endfunction

    function automatic bit model_load_use();
        return m_ex.v && m_ex.ld && (m_ex.rd != 0) && id_valid_i &&
               ((rs1_used_id_i && rs1_address_id_i == m_ex.rd) ||
                (rs2_used_id_i && rs2_address_id_i == m_ex.rd));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit busy;
        busy = (div_left > 0);
        chk("m_we_ex",    32'(rd_we_ex_o),       32'(fwd_we(m_ex)));
        chk("m_rd_ex",    32'(rd_address_ex_o),  32'(fwd_rd(m_ex)));
        chk("m_we_mem",   32'(rd_we_mem_o),      32'(fwd_we(m_mem)));
        chk("m_rd_mem",   32'(rd_address_mem_o), 32'(fwd_rd(m_mem)));
        chk("m_we_wb",    32'(rd_we_wb_o),       32'(fwd_we(m_wb)));
        chk("m_rd_wb",    32'(rd_address_wb_o),  32'(fwd_rd(m_wb)));
        chk("m_div_busy", 32'(div_busy_o),       32'(busy));
        chk("m_stall",    32'(stall_o),          32'(busy || model_load_use()));
    endtask

    task automatic model_edge();
        instr_t id_s;
        bit lu;
        lu = model_load_use();
        id_s.v = 1; id_s.we = rd_we_id_i; id_s.rd = rd_address_id_i; id_s.ld = mem_read_id_i;
        if (rst) begin
            m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); div_left = 0;
        end else if (div_left > 0) begin
            m_wb = m_mem; m_mem = bubble(); div_left--;
        end else if (lu || flush_i || !id_valid_i) begin
            m_wb = m_mem; m_mem = m_ex; m_ex = bubble();
        end else begin
            m_wb = m_mem; m_mem = m_ex; m_ex = id_s;
            div_left = div_id_i ? LAT - 1 : 0;
        end
    endtask

    task automatic drive(input bit v, input bit we, input bit [4:0] rd,
                         input bit [4:0] s1, input bit u1, input bit [4:0] s2, input bit u2,
                         input bit ld, input bit dv, input bit fl);
        id_valid_i = v; rd_we_id_i = we; rd_address_id_i = rd;
        rs1_address_id_i = s1; rs1_used_id_i = u1;
        rs2_address_id_i = s2; rs2_used_id_i = u2;
        mem_read_id_i = ld; div_id_i = dv; flush_i = fl;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (model_ok) check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        nop();
        @(posedge clk);
        #1;
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); div_left = 0;
        model_ok = 1'b1;
        chk("rst_we_ex",   32'(rd_we_ex_o),       0);
        chk("rst_rd_ex",   32'(rd_address_ex_o),  0);
        chk("rst_we_mem",  32'(rd_we_mem_o),      0);
        chk("rst_rd_mem",  32'(rd_address_mem_o), 0);
        chk("rst_we_wb",   32'(rd_we_wb_o),       0);
        chk("rst_rd_wb",   32'(rd_address_wb_o),  0);
        chk("rst_stall",   32'(stall_o),          0);
        chk("rst_busy",    32'(div_busy_o),       0);
        tick();
        rst = 1'b0;

        // back-to-back ALU: addi x5 then add x6,x5,x5
        drive(1, 1, 5, 0, 1, 0, 0, 0, 0, 0);
        chk("b2b_stall0", 32'(stall_o), 0);
        tick();
        drive(1, 1, 6, 5, 1, 5, 1, 0, 0, 0);
        chk("b2b_stall1", 32'(stall_o), 0);
        tick();
        nop();
        chk("b2b_we_mem", 32'(rd_we_mem_o), 1);
        chk("b2b_rd_mem", 32'(rd_address_mem_o), 5);
        tick();
        chk("b2b_we_wb",  32'(rd_we_wb_o), 1);
        chk("b2b_rd_wb",  32'(rd_address_wb_o), 5);
        tick(); tick();

        // load-use: lw x7 then add x8,x1,x7
        drive(1, 1, 7, 1, 1, 0, 0, 1, 0, 0);
        tick();
        drive(1, 1, 8, 1, 1, 7, 1, 0, 0, 0);
        chk("lu_stall", 32'(stall_o), 1);
        tick();
        chk("lu_stall_clr", 32'(stall_o), 0);
        chk("lu_ex_bubble", 32'(rd_we_ex_o), 0);
        chk("lu_we_mem",    32'(rd_we_mem_o), 1);
        chk("lu_rd_mem",    32'(rd_address_mem_o), 7);
        tick();
        nop(); tick(); tick(); tick();

        // x0 destination: lw x0 then reader of x0
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 1, 4, 0, 1, 0, 1, 0, 0, 0);
        chk("x0_stall", 32'(stall_o), 0);
        tick();
        nop();
        chk("x0_we_mem", 32'(rd_we_mem_o), 0);
        tick();
        chk("x0_we_wb", 32'(rd_we_wb_o), 0);
        tick(); tick();

        // divide x9 in ID at cycle 0; an add x10 waits behind it
        drive(1, 1, 9, 1, 1, 2, 1, 0, 1, 0);
        tick();
        drive(1, 1, 10, 1, 1, 2, 1, 0, 0, 0);
        chk("div_busy_c1",  32'(div_busy_o), 1);
        chk("div_stall_c1", 32'(stall_o), 1);
        chk("div_rd_ex_c1", 32'(rd_address_ex_o), 9);
        tick();
        chk("div_mem_c2", 32'(rd_we_mem_o), 0);
        tick(); tick();
        chk("div_busy_c4", 32'(div_busy_o), 0);
        chk("div_mem_c4",  32'(rd_we_mem_o), 0);
        chk("div_rd_ex_c4", 32'(rd_address_ex_o), 9);
        tick();
        nop();
        chk("div_we_mem_c5", 32'(rd_we_mem_o), 1);
        chk("div_rd_mem_c5", 32'(rd_address_mem_o), 9);
        tick(); tick(); tick();

        // flush with a valid addi x3 in ID
        drive(1, 1, 3, 0, 1, 0, 0, 0, 0, 1);
        tick();
        nop();
        chk("fl_we_ex", 32'(rd_we_ex_o), 0);
        chk("fl_rd_ex", 32'(rd_address_ex_o), 0);
        tick();

        // reset in the middle of a divide
        drive(1, 1, 9, 0, 0, 0, 0, 0, 1, 0);
        tick();
        nop();
        tick();
        rst = 1'b1;
        chk("rdiv_busy_pre", 32'(div_busy_o), 1);
        tick();
        chk("rdiv_busy",  32'(div_busy_o), 0);
        chk("rdiv_stall", 32'(stall_o), 0);
        chk("rdiv_rd_ex", 32'(rd_address_ex_o), 0);
        chk("rdiv_we_ex", 32'(rd_we_ex_o), 0);
        rst = 1'b0;
        tick();

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            bit dv, ld;
            rst = ($urandom_range(0, 59) == 0);
            dv  = ($urandom_range(0, 7) == 0);
            ld  = !dv && ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ld, dv, $urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b0;
        nop();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
